// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of an asynchronous FIFO.
// Accepts producer writes into an external register file. It maintains a binary
// and a Gray write pointer, and synchronises the Gray read pointer from the read
// clock domain. From these it derives the full flag, the occupancy count and a
// sticky overflow flag.
// Optional feature: define FIFO_WR_ALMOST_FULL_EN to add the registered almost_full output.
module fifo_wr_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 64,
    parameter int ADDR         = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 4
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [ADDR:0]    rptr_gray,
    input  logic             ovf_clr,
    output logic             full,
    output logic             wr_ack,
    output logic             ram_en,
    output logic             ram_wr,
    output logic [ADDR-1:0]  ram_addr,
    output logic [WIDTH-1:0] ram_din,
    output logic [ADDR:0]    wptr_gray,
    output logic [ADDR:0]    wr_count,
`ifdef FIFO_WR_ALMOST_FULL_EN
    output logic             almost_full,
`endif
    output logic             overflow
);

    // Write pointer state. The extra MSB distinguishes a full FIFO from an empty one.
    logic [ADDR:0] wbin_reg;
    logic [ADDR:0] wbin_next;
    logic [ADDR:0] wgray_reg;
    logic [ADDR:0] wgray_next;

    // Read pointer after the synchroniser, in Gray and in binary form.
    logic [ADDR:0] sync_reg [SYNC_STAGES];
    logic [ADDR:0] rgray_s;
    logic [ADDR:0] rbin_s;
    logic [ADDR:0] full_cmp;

    logic          accept;
    logic          full_reg;
    logic          full_next;
    logic [ADDR:0] count_reg;
    logic [ADDR:0] count_next;
    logic          overflow_reg;
    logic          overflow_next;

    // A write is taken only while the FIFO is not full. The storage captures it on the same edge.
    assign accept   = wr_req & ~full_reg;
    assign wr_ack   = accept;
    assign ram_en   = accept;
    assign ram_wr   = accept;
    assign ram_addr = wbin_reg[ADDR-1:0];
    assign ram_din  = wr_data;

    assign wbin_next  = wbin_reg + {{ADDR{1'b0}}, accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    assign rgray_s = sync_reg[SYNC_STAGES-1];

    // Gray to binary conversion: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= ADDR; gi++) begin : g_rbin
            assign rbin_s[gi] = ^rgray_s[ADDR:gi];
        end
    endgenerate

    // The FIFO is full when the write pointer is one lap ahead of the read pointer.
    // In Gray code, that is when the top two bits are inverted and the rest are equal.
    assign full_cmp      = {~rgray_s[ADDR:ADDR-1], rgray_s[ADDR-2:0]};
    assign full_next     = (wgray_next == full_cmp);
    assign count_next    = wbin_next - rbin_s;
    // Setting the flag takes priority over clearing it when both happen in the same cycle.
    assign overflow_next = (wr_req & full_reg) | (overflow_reg & ~ovf_clr);

    // Read pointer synchroniser: a plain flop chain with no logic between stages.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
            sync_reg[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
    end

    // Write pointers, flags and occupancy, all updated together on each write-clock edge.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            wbin_reg     <= '0;
            wgray_reg    <= '0;
            full_reg     <= 1'b0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wgray_reg    <= wgray_next;
            full_reg     <= full_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign full      = full_reg;
    assign wptr_gray = wgray_reg;
    assign wr_count  = count_reg;
    assign overflow  = overflow_reg;

`ifdef FIFO_WR_ALMOST_FULL_EN
    // The count is widened by one bit so that DEPTH - count cannot wrap around.
    localparam logic [ADDR+1:0] DEPTH_W = (ADDR+2)'(DEPTH);
    localparam logic [ADDR+1:0] AFULL_W = (ADDR+2)'(AFULL_THRESH);

    logic afull_reg;
    logic afull_next;

    assign afull_next = ((DEPTH_W - {1'b0, count_next}) <= AFULL_W);

    // almost_full is registered from the same next-state count as wr_count.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) afull_reg <= 1'b0;
        else      afull_reg <= afull_next;
    end

    assign almost_full = afull_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed and random test of the FIFO write controller.
// The reference model counts writes and reads as unbounded integers.
// It delays the read count through a queue that stands for the synchroniser latency.
// Build with FIFO_WR_ALMOST_FULL_EN defined to also check almost_full.
module tb_fifo_wr_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int ADDR  = 6;
    localparam int SS    = 2;
    localparam int AF    = 4;

    logic             clka = 1'b0;
    logic             rsta = 1'b1;
    logic             wr_req = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [ADDR:0]    rptr_gray = '0;
    logic             ovf_clr = 1'b0;
    logic             full, wr_ack, ram_en, ram_wr, overflow;
    logic [ADDR-1:0]  ram_addr;
    logic [WIDTH-1:0] ram_din;
    logic [ADDR:0]    wptr_gray, wr_count;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic             almost_full;
`endif

    fifo_wr_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
        .SYNC_STAGES(SS), .AFULL_THRESH(AF)
    ) dut (
        .clka(clka), .rsta(rsta), .wr_req(wr_req), .wr_data(wr_data),
        .rptr_gray(rptr_gray), .ovf_clr(ovf_clr), .full(full), .wr_ack(wr_ack),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
        .wptr_gray(wptr_gray), .wr_count(wr_count),
`ifdef FIFO_WR_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .overflow(overflow)
    );

    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int   wcnt, rcnt, rsync, m_count;
    int   pipe[$];
    logic m_full, m_ovf, m_afull;

    function automatic logic [ADDR:0] gray(input int v);
        logic [ADDR:0] b;
        b = 7'(v % 128);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wcnt = 0; rcnt = 0; rsync = 0; m_count = 0;
        m_full = 1'b0; m_ovf = 1'b0; m_afull = 1'b0;
        pipe.delete();
        for (int i = 0; i < SS - 1; i++) pipe.push_back(0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_count"}, 32'(wr_count), 0);
        chk({tag, "_wgray"}, 32'(wptr_gray), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk({tag, "_afull"}, 32'(almost_full), 0);
`endif
    endtask

    // One clock cycle. The task is entered at a falling edge and returns at the next falling edge.
    task automatic step(input logic req, input logic [7:0] d, input logic clr, input logic rinc);
        logic acc;
        wr_req = req; wr_data = d; ovf_clr = clr;
        if (rinc && rcnt < wcnt) rcnt++;
        rptr_gray = gray(rcnt);
        #1;
        acc = req & ~m_full;
        chk("wr_ack", 32'(wr_ack), 32'(acc));
        chk("ram_en", 32'(ram_en), 32'(acc));
        chk("ram_wr", 32'(ram_wr), 32'(acc));
        if (acc) begin
            chk("ram_addr", 32'(ram_addr), 32'(wcnt % DEPTH));
            chk("ram_din", 32'(ram_din), 32'(d));
        end
        @(posedge clka);
        if (acc) wcnt++;
        if (req && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        m_count = wcnt - rsync;
        m_full  = (m_count == DEPTH);
        m_afull = ((DEPTH - m_count) <= AF);
        pipe.push_back(rcnt);
        rsync = pipe.pop_front();
        #1;
        chk("full", 32'(full), 32'(m_full));
        chk("wr_count", 32'(wr_count), 32'(m_count));
        chk("wptr_gray", 32'(wptr_gray), 32'(gray(wcnt)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(m_afull));
`endif
        @(negedge clka);
    endtask

    // Asserts reset between clock edges while a write is requested.
    // Outputs must clear immediately and stay clear across a clock edge.
    task automatic async_reset(input string tag);
        #2;
        wr_req = 1'b1; rptr_gray = '0;
        rsta = 1'b1;
        #1;
        model_reset();
        chk_zero({tag, "_async"});
        @(posedge clka);
        #1;
        chk_zero({tag, "_held"});
        @(negedge clka);
        rsta = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        chk_zero("por");
        @(posedge clka);
        #1;
        chk_zero("por_held");
        @(negedge clka);
        rsta = 1'b0;

        // Write 64 entries back to back with the reader idle, which fills the FIFO.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i) ^ 8'hA5, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(wr_count), 64);

        // Writes while full are dropped and set overflow. A set in the same cycle as a clear wins.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        chk("ovf_set_wins", 32'(overflow), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_cleared", 32'(overflow), 0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("ovf_reset_pre", 32'(overflow), 1);

        // Reset while full with overflow set.
        async_reset("rst_full");

        // Refill the FIFO. After one read, full must clear exactly three cycles later.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("full_hold1", 32'(full), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_hold2", 32'(full), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_release", 32'(full), 0);
        chk("count_after_read", 32'(wr_count), 63);

        // Drain the FIFO, then write 130 times with the reader following.
        // The write pointer wraps from 127 to 0.
        for (int i = 0; i < 70; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 130; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);

        // Random traffic: first with the writer dominant, then with the reader dominant.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 2) == 0), 8'($urandom),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));

        // Reset in the middle of a 10-write burst.
        async_reset("rst_pre");
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("burst_count", 32'(wr_count), 10);
        async_reset("rst_burst");

        // almost_full boundary: clear after 59 writes, set after the 60th.
        for (int i = 0; i < 59; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("afull_59", 32'(almost_full), 0);
`endif
        step(1'b1, 8'h60, 1'b0, 1'b0);
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("afull_60", 32'(almost_full), 1);
`endif
        chk("count_60", 32'(wr_count), 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, write data width.
REQ-002 SHALL have parameter DEPTH, default 64, storage entries; DEPTH = 2^ADDR.
REQ-003 SHALL have parameter ADDR, default 6, storage address width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, read-pointer synchronizer depth (>=2).
REQ-005 SHALL have parameter AFULL_THRESH, default 4, free-entry count at which almost_full asserts.
REQ-006 SHALL have port clka, input, 1, write-domain clock; all logic on posedge.
REQ-007 SHALL have port rsta, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port wr_req, input, 1, producer write request.
REQ-009 SHALL have port wr_data, input, WIDTH, producer write data.
REQ-010 SHALL have port rptr_gray, input, ADDR+1, read pointer (Gray), from clkb domain.
REQ-011 SHALL have port ovf_clr, input, 1, clears overflow.
REQ-012 SHALL have port full, output, 1, registered full flag.
REQ-013 SHALL have port wr_ack, output, 1, write accepted this cycle (combinational).
REQ-014 SHALL have ports ram_en, ram_wr (output, 1), ram_addr (output, ADDR), ram_din (output, WIDTH): register-file write port.
REQ-015 SHALL have port wptr_gray, output, ADDR+1, registered write pointer (Gray), to read domain.
REQ-016 SHALL have port wr_count, output, ADDR+1, registered occupancy as seen from write domain.
REQ-017 SHALL have port overflow, output, 1, sticky write-while-full flag.

Function
REQ-018 SHALL define accept = wr_req & ~full; wr_ack = ram_en = ram_wr = accept.
REQ-019 SHALL drive ram_addr = wbin[ADDR-1:0], ram_din = wr_data, same cycle as accept; storage latches at the same clka edge.
REQ-020 SHALL advance binary pointer wbin (ADDR+1 bits) by 1 on each accept, wrapping 2^(ADDR+1)-1 -> 0.
REQ-021 SHALL register wptr_gray = wbin_next ^ (wbin_next >> 1) at the same edge as wbin.
REQ-022 SHALL pass rptr_gray through SYNC_STAGES flops on clka; no logic between stages; rgray_s = last stage.
REQ-023 SHALL register full_next = (wgray_next == {~rgray_s[ADDR:ADDR-1], rgray_s[ADDR-2:0]}); full asserts the cycle after the filling write.
REQ-024 SHALL deassert full no earlier than SYNC_STAGES+1 clka cycles after rptr_gray change; full never deasserts while DEPTH entries unread.
REQ-025 SHALL register wr_count = (wbin_next - gray2bin(rgray_s)) mod 2^(ADDR+1); range 0..DEPTH.
REQ-026 SHALL set overflow when wr_req & full; clear on ovf_clr; set wins if simultaneous; write is dropped, pointers unchanged.
REQ-027 SHALL leave pointers unchanged when wr_req=0 or full=1.

Reset
REQ-028 SHALL, on rsta=1, immediately clear wbin, wptr_gray, sync flops, full, wr_count, overflow (and almost_full) to 0.
REQ-029 SHALL hold all registers at 0 while rsta=1; first accept possible on first clka edge after release.
REQ-030 SHALL require read-side reset asserted together with rsta; mid-operation reset discards FIFO contents (count returns 0).

Configuration
REQ-031 SHALL, with macro FIFO_WR_ALMOST_FULL_EN defined, add output almost_full (1 bit), registered, = (DEPTH - wr_count_next) <= AFULL_THRESH.
REQ-032 SHALL, without FIFO_WR_ALMOST_FULL_EN, omit the almost_full port and its logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, rptr_gray=0, 64 back-to-back wr_req -> ram_addr 0..63, wr_ack all 64, full=1 cycle after 64th, wr_count=64.
REQ-034 SHALL cover: full=1, wr_req=1 -> wr_ack=0, ram_en=0, overflow=1 next cycle; ovf_clr=1 -> overflow=0.
REQ-035 SHALL cover: full, rptr_gray 7'b0000000 -> 7'b0000001 -> full=0 exactly SYNC_STAGES+1=3 cycles later, wr_count=63.
REQ-036 SHALL cover: wrap, 130 writes with reader tracking -> wbin 127 -> 0, wptr_gray 7'b1000000 -> 7'b0000000, no false full.
REQ-037 SHALL cover: rsta pulse mid-burst (10 writes) -> wptr_gray, wr_count, full, overflow = 0 asynchronously, before next clka edge.
REQ-038 SHALL cover (FIFO_WR_ALMOST_FULL_EN): 59 writes -> almost_full=0; 60th write -> almost_full=1 next cycle (AFULL_THRESH=4).
